// File: rtl/log_motion_ctrl_if.sv
// ---------------------------------------------------------------------------
// log_motion_ctrl_if
// Bundles the control pulses, start offsets and committed log positions of
// log_motion_ctrl.
//   master : drives startOfFrame, load_level, speed, start_offsetX/Y;
//            observes logX/logY, busy, frame_done, overrun
//   slave  : the motion controller itself (opposite directions)
// Per-log fields are packed arrays indexed [log][bit].
// ---------------------------------------------------------------------------
interface log_motion_ctrl_if #(
    parameter int NUM_OF_LOGS = 30,
    parameter int SPEED_W     = 3
);
    logic                         startOfFrame;
    logic                         load_level;
    logic [SPEED_W-1:0]           speed;
    logic [NUM_OF_LOGS-1:0][8:0]  start_offsetX;
    logic [NUM_OF_LOGS-1:0][8:0]  start_offsetY;
    logic [NUM_OF_LOGS-1:0][9:0]  logX;
    logic [NUM_OF_LOGS-1:0][8:0]  logY;
    logic                         busy;
    logic                         frame_done;
    logic                         overrun;

    modport master (
        output startOfFrame, load_level, speed, start_offsetX, start_offsetY,
        input  logX, logY, busy, frame_done, overrun
    );

    modport slave (
        input  startOfFrame, load_level, speed, start_offsetX, start_offsetY,
        output logX, logY, busy, frame_done, overrun
    );
endinterface

// File: rtl/log_motion_ctrl.sv
// ---------------------------------------------------------------------------
// log_motion_ctrl
// Keeps the X/Y position of every log. A load_level pulse loads the start
// offsets (Y folded into 0..SCREEN_H-1); a startOfFrame pulse moves every log
// horizontally by the latched speed, even logs to the right and odd logs to
// the left, wrapping at SCREEN_W. Logs are processed one per clock into a
// shadow buffer, and the whole buffer is copied to the outputs in a single
// COMMIT cycle so the drawing stage never sees a half-updated frame.
// Ports:
//   CLK, resetN : clock, asynchronous active-low reset
//   bus (slave) : startOfFrame, load_level, speed, start_offsetX/Y in;
//                 logX, logY, busy, frame_done, overrun out
// ---------------------------------------------------------------------------
module log_motion_ctrl #(
    parameter int NUM_OF_LOGS = 30,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPEED_W     = 3
) (
    input logic              CLK,
    input logic              resetN,
    log_motion_ctrl_if.slave bus
);

    localparam int IDX_W = (NUM_OF_LOGS > 1) ? $clog2(NUM_OF_LOGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_LOGS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, UPDATE, COMMIT} state_t;

    state_t state_reg, state_next;

    logic                        busy;
    logic                        frame_done;
    logic                        last_idx;
    logic [IDX_W-1:0]            index_reg;
    logic [SPEED_W-1:0]          spd_reg;
    logic                        overrun_reg;

    logic [9:0]                  shadow_x_reg [NUM_OF_LOGS];
    logic [8:0]                  shadow_y_reg [NUM_OF_LOGS];
    logic [NUM_OF_LOGS-1:0][9:0] shadow_x_flat;
    logic [NUM_OF_LOGS-1:0][8:0] shadow_y_flat;
    logic [NUM_OF_LOGS-1:0][9:0] log_x_reg;
    logic [NUM_OF_LOGS-1:0][8:0] log_y_reg;

    logic [10:0]                 cur_x_w;
    logic [10:0]                 spd_w;
    logic [10:0]                 sum_right;
    logic [10:0]                 wrap_left;
    logic [9:0]                  upd_x;
    logic [9:0]                  load_x;
    logic [8:0]                  off_y;
    logic [8:0]                  load_y;

    assign last_idx = (index_reg == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // load_level wins everywhere: it preempts startOfFrame in IDLE, aborts an
    // UPDATE, restarts a LOAD, and follows a COMMIT without returning to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.load_level) begin
                    state_next = LOAD;
                end else if (bus.startOfFrame) begin
                    state_next = UPDATE;
                end
            end
            LOAD, UPDATE: begin
                if (bus.load_level) begin
                    state_next = LOAD;
                end else if (last_idx) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = bus.load_level ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state_reg != IDLE);
        frame_done = (state_reg == COMMIT);
    end

    // ---------------- per-log arithmetic for the current index ----------------
    // 11-bit intermediates: x <= 639 and speed <= 2^SPEED_W-1 never overflow.
    always_comb begin
        cur_x_w   = {1'b0, shadow_x_reg[index_reg]};
        spd_w     = 11'(spd_reg);
        sum_right = cur_x_w + spd_w;
        wrap_left = cur_x_w + 11'(SCREEN_W) - spd_w;
        if (index_reg[0] == 1'b0) begin
            upd_x = (sum_right >= 11'(SCREEN_W)) ? 10'(sum_right - 11'(SCREEN_W))
                                                 : 10'(sum_right);
        end else begin
            upd_x = (cur_x_w < spd_w) ? 10'(wrap_left) : 10'(cur_x_w - spd_w);
        end
        // 9-bit X offsets are always below SCREEN_W; only Y needs folding
        load_x = {1'b0, bus.start_offsetX[index_reg]};
        off_y  = bus.start_offsetY[index_reg];
        load_y = ({1'b0, off_y} >= 10'(SCREEN_H)) ? 9'({1'b0, off_y} - 10'(SCREEN_H))
                                                  : off_y;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            index_reg   <= '0;
            spd_reg     <= '0;
            overrun_reg <= 1'b0;
            log_x_reg   <= '0;
            log_y_reg   <= '0;
            for (int i = 0; i < NUM_OF_LOGS; i++) begin
                shadow_x_reg[i] <= '0;
                shadow_y_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    index_reg <= '0;
                    if (bus.load_level) begin
                        overrun_reg <= 1'b0;
                    end else if (bus.startOfFrame) begin
                        // held for the whole update so mid-frame speed changes are ignored
                        spd_reg <= bus.speed;
                    end
                end
                LOAD: begin
                    if (bus.load_level) begin
                        index_reg <= '0;
                    end else begin
                        shadow_x_reg[index_reg] <= load_x;
                        shadow_y_reg[index_reg] <= load_y;
                        index_reg <= last_idx ? '0 : index_reg + IDX_W'(1);
                    end
                end
                UPDATE: begin
                    if (bus.load_level) begin
                        // partially updated shadow is overwritten by the LOAD that follows
                        index_reg <= '0;
                    end else begin
                        shadow_x_reg[index_reg] <= upd_x;
                        index_reg <= last_idx ? '0 : index_reg + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    log_x_reg <= shadow_x_flat;
                    log_y_reg <= shadow_y_flat;
                    index_reg <= '0;
                end
                default: index_reg <= '0;
            endcase
            if (busy && bus.startOfFrame) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // gather the shadow entries into one word for the atomic commit
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OF_LOGS; gi++) begin : g_pack
            assign shadow_x_flat[gi] = shadow_x_reg[gi];
            assign shadow_y_flat[gi] = shadow_y_reg[gi];
        end
    endgenerate

    assign bus.logX       = log_x_reg;
    assign bus.logY       = log_y_reg;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_log_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_log_motion_ctrl
// Self-checking bench for log_motion_ctrl. Expected frames are pushed to a
// queue when a request is driven and popped on the commit edge.
// ---------------------------------------------------------------------------
module tb_log_motion_ctrl;

    localparam int N  = 30;
    localparam int SW = 640;
    localparam int SH = 480;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    log_motion_ctrl_if #(.NUM_OF_LOGS(N), .SPEED_W(3)) bus ();

    log_motion_ctrl #(
        .NUM_OF_LOGS (N),
        .SCREEN_W    (SW),
        .SCREEN_H    (SH),
        .SPEED_W     (3)
    ) dut (
        .CLK    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct packed {
        logic [N-1:0][9:0] x;
        logic [N-1:0][8:0] y;
    } frame_t;

    frame_t            exp_q [$];
    frame_t            model_f;
    frame_t            committed_f;
    frame_t            f;
    logic [N-1:0][8:0] offx;
    logic [N-1:0][8:0] offy;
    int                checks = 0;
    int                errors = 0;

    function automatic frame_t model_load(input logic [N-1:0][8:0] ox,
                                          input logic [N-1:0][8:0] oy);
        frame_t r;
        for (int i = 0; i < N; i++) begin
            int yv;
            yv = int'(oy[i]);
            if (yv >= SH) yv = yv - SH;
            r.x[i] = 10'(int'(ox[i]));
            r.y[i] = 9'(yv);
        end
        return r;
    endfunction

    function automatic frame_t model_update(input frame_t c, input int s);
        frame_t r;
        r = c;
        for (int i = 0; i < N; i++) begin
            int xv;
            xv = int'(c.x[i]);
            if (i % 2 == 0) xv = (xv + s) % SW;
            else            xv = (xv + SW - s) % SW;
            r.x[i] = 10'(xv);
        end
        return r;
    endfunction

    function automatic frame_t pop_exp();
        frame_t r;
        r = 'x;
        if (exp_q.size() != 0) r = exp_q.pop_front();
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_load();
        bus.start_offsetX = offx;
        bus.start_offsetY = offy;
        model_f = model_load(offx, offy);
        exp_q.push_back(model_f);
    endtask

    task automatic push_sof(input int s);
        bus.speed = 3'(s);
        model_f = model_update(model_f, s);
        exp_q.push_back(model_f);
    endtask

    // one-cycle pulse driven now; returns just after the sampling edge
    task automatic pulse(input bit is_load, output int cyc, output int busy_cnt);
        if (is_load) bus.load_level = 1'b1;
        else         bus.startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        bus.load_level   = 1'b0;
        bus.startOfFrame = 1'b0;
        cyc      = 1;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    endtask

    // advance until frame_done is seen or the cycle budget runs out
    task automatic wait_done(inout int cyc, inout int busy_cnt);
        while (bus.frame_done !== 1'b1 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        step(3);
        checks++;
        if (bus.logX !== '0) begin errors++; $display("FAIL reset_logX got %h want 0", bus.logX); end
        checks++;
        if (bus.logY !== '0) begin errors++; $display("FAIL reset_logY got %h want 0", bus.logY); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        resetN = 1'b1;
        step(2);
        $display("reset released");
    endtask

    task automatic test_load();
        int cyc, bc;
        offx[0] = 9'd100;
        offy[0] = 9'd300;
        offy[1] = 9'd500;
        push_load();
        pulse(1'b1, cyc, bc);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 31) begin errors++; $display("FAIL load_latency got %0d want 31", cyc); end
        checks++;
        if (bus.logX !== committed_f.x) begin errors++; $display("FAIL load_hold got %h want %h", bus.logX, committed_f.x); end
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL load_commit got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        checks++;
        if (bc != 31 || bus.busy !== 1'b0) begin errors++; $display("FAIL load_busy_cycles got %0d busy=%b want 31 busy=0", bc, bus.busy); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL load_done_width got %b want 0", bus.frame_done); end
        checks++;
        if (bus.logX[0] !== 10'd100 || bus.logY[0] !== 9'd300 || bus.logY[1] !== 9'd20) begin
            errors++;
            $display("FAIL load_values got x0=%0d y0=%0d y1=%0d want 100 300 20", bus.logX[0], bus.logY[0], bus.logY[1]);
        end
        $display("frame load lat=%0d busy=%0d", cyc, bc);
    endtask

    task automatic test_wrap();
        int cyc, bc;
        offx[0] = 9'd511;
        offx[1] = 9'd129;
        push_load();
        pulse(1'b1, cyc, bc);
        wait_done(cyc, bc);
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL wrap_load got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        // walk log 0 up to 638 and log 1 down to 2 (18 x 7 + 1 = 127)
        for (int k = 0; k < 20; k++) begin
            push_sof((k < 18) ? 7 : ((k == 18) ? 1 : 5));
            pulse(1'b0, cyc, bc);
            wait_done(cyc, bc);
            checks++;
            if (bus.logX !== committed_f.x) begin errors++; $display("FAIL wrap_hold%0d got %h want %h", k, bus.logX, committed_f.x); end
            step(1);
            f = pop_exp();
            checks++;
            if (bus.logX !== f.x || bus.logY !== f.y) begin
                errors++;
                $display("FAIL wrap_commit%0d got X=%h Y=%h want X=%h Y=%h", k, bus.logX, bus.logY, f.x, f.y);
            end
            committed_f = f;
            $display("frame wrap%0d lat=%0d x0=%0d x1=%0d", k, cyc, bus.logX[0], bus.logX[1]);
        end
        checks++;
        if (bus.logX[0] !== 10'd3 || bus.logX[1] !== 10'd637) begin
            errors++;
            $display("FAIL wrap_values got x0=%0d x1=%0d want 3 637", bus.logX[0], bus.logX[1]);
        end
    endtask

    task automatic test_multi();
        int cyc, bc, nd;
        offx[2] = 9'd200;
        offx[3] = 9'd200;
        push_load();
        pulse(1'b1, cyc, bc);
        wait_done(cyc, bc);
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL multi_load got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            push_sof(7);
            pulse(1'b0, cyc, bc);
            bus.speed = 3'd2;  // must not affect the running update
            wait_done(cyc, bc);
            if (bus.frame_done === 1'b1) nd++;
            step(1);
            f = pop_exp();
            checks++;
            if (bus.logX !== f.x || bus.logY !== f.y) begin
                errors++;
                $display("FAIL multi_commit%0d got X=%h Y=%h want X=%h Y=%h", k, bus.logX, bus.logY, f.x, f.y);
            end
            committed_f = f;
            $display("frame multi%0d lat=%0d x2=%0d x3=%0d", k, cyc, bus.logX[2], bus.logX[3]);
            step(40 - cyc - 1);
        end
        checks++;
        if (nd != 3) begin errors++; $display("FAIL multi_done_count got %0d want 3", nd); end
        checks++;
        if (bus.logX[2] !== 10'd221 || bus.logX[3] !== 10'd179) begin
            errors++;
            $display("FAIL multi_values got x2=%0d x3=%0d want 221 179", bus.logX[2], bus.logX[3]);
        end
    endtask

    task automatic test_overrun();
        int cyc, bc, c2, b2, nd;
        push_sof(1);
        pulse(1'b0, cyc, bc);
        step(9);
        cyc += 9;
        pulse(1'b0, c2, b2);  // arrives 10 cycles after the first: ignored
        cyc += 1;
        wait_done(cyc, bc);
        checks++;
        if (cyc != 31) begin errors++; $display("FAIL overrun_latency got %0d want 31", cyc); end
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", bus.overrun); end
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL overrun_commit got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (bus.frame_done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL overrun_extra_done got %0d want 0", nd); end
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", bus.overrun); end
        offx[4] = 9'd450;
        push_load();
        pulse(1'b1, cyc, bc);
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", bus.overrun); end
        wait_done(cyc, bc);
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL overrun_reload got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        $display("frame overrun_reload lat=%0d", cyc);
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        push_sof(0);
        pulse(1'b0, cyc, bc);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 31) begin errors++; $display("FAIL b2b_speed0_latency got %0d want 31", cyc); end
        // load_level arrives during COMMIT
        offx[5] = 9'd77;
        offy[5] = 9'd481;
        push_load();
        pulse(1'b1, cyc, bc);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y || bus.logX !== committed_f.x) begin
            errors++;
            $display("FAIL b2b_speed0_commit got X=%h want X=%h", bus.logX, f.x);
        end
        committed_f = f;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_load_started got busy=%b want 1", bus.busy); end
        wait_done(cyc, bc);
        checks++;
        if (cyc != 31) begin errors++; $display("FAIL b2b_load_latency got %0d want 31", cyc); end
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL b2b_load_commit got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        $display("frame b2b lat=%0d x5=%0d y5=%0d", cyc, bus.logX[5], bus.logY[5]);
    endtask

    task automatic test_abort();
        int cyc, bc, nd;
        offx[6] = 9'd300;
        bus.start_offsetX = offx;
        push_sof(4);
        pulse(1'b0, cyc, bc);
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (bus.frame_done === 1'b1) nd++;
        end
        void'(exp_q.pop_back());  // this update is aborted
        push_load();
        pulse(1'b1, cyc, bc);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 31 || nd != 0) begin errors++; $display("FAIL abort_latency got %0d early=%0d want 31 early=0", cyc, nd); end
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL abort_commit got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        $display("frame abort_reload lat=%0d", cyc);
    endtask

    task automatic test_reset_mid();
        int cyc, bc, nd;
        push_sof(3);
        pulse(1'b0, cyc, bc);
        step(10);
        resetN = 1'b0;
        #1;
        checks++;
        if (bus.logX !== '0 || bus.logY !== '0) begin errors++; $display("FAIL rstmid_outputs got X=%h Y=%h want 0", bus.logX, bus.logY); end
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags got busy=%b done=%b ovr=%b want 0 0 0", bus.busy, bus.frame_done, bus.overrun);
        end
        exp_q.delete();
        model_f = '0;
        committed_f = '0;
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            if (bus.frame_done === 1'b1) nd++;
        end
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            if (bus.frame_done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got done=%0d busy=%b want 0 0", nd, bus.busy); end
        push_load();
        pulse(1'b1, cyc, bc);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 31) begin errors++; $display("FAIL rstmid_latency got %0d want 31", cyc); end
        step(1);
        f = pop_exp();
        checks++;
        if (bus.logX !== f.x || bus.logY !== f.y) begin
            errors++;
            $display("FAIL rstmid_commit got X=%h Y=%h want X=%h Y=%h", bus.logX, bus.logY, f.x, f.y);
        end
        committed_f = f;
        $display("frame rstmid_reload lat=%0d", cyc);
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.load_level   = 1'b0;
        bus.speed        = 3'd0;
        for (int i = 0; i < N; i++) begin
            offx[i] = 9'(i * 17);
            offy[i] = 9'(i * 16 + 7);
        end
        bus.start_offsetX = offx;
        bus.start_offsetY = offy;
        model_f     = '0;
        committed_f = '0;

        test_reset();
        test_load();
        test_wrap();
        test_multi();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
